uart_scope_responder: RTL and testbench

//  Host-side command responder that sits on the byte interface of the 230400-baud UART.

---
 rtl/uart_scope_pkg.sv | 30 +++
 rtl/uart_scope_if.sv | 22 ++
 rtl/uart_byte_sender.sv | 53 +++++
 rtl/uart_scope_responder.sv | 133 +++++++++++++
 tb/tb_uart_scope_responder.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_scope_pkg.sv
// Shared constants for the UART scope responder: command codes, frame sync byte,
// and the state encodings of the responder FSM and the byte sender.
package uart_scope_pkg;

   localparam logic [7:0] SYNC_BYTE  = 8'hA5;
   localparam logic [7:0] CMD_ARM    = 8'h41;
   localparam logic [7:0] CMD_READ   = 8'h52;
   localparam logic [7:0] CMD_STATUS = 8'h3F;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_HDR       = 4'd1;
   localparam logic [3:0] ST_LEN_HI    = 4'd2;
   localparam logic [3:0] ST_LEN_LO    = 4'd3;
   localparam logic [3:0] ST_MEM_RD    = 4'd4;
   localparam logic [3:0] ST_DATA      = 4'd5;
   localparam logic [3:0] ST_CSUM      = 4'd6;
   localparam logic [3:0] ST_STAT_HDR  = 4'd7;
   localparam logic [3:0] ST_STAT_BYTE = 4'd8;

   localparam logic [1:0] TX_IDLE    = 2'd0;
   localparam logic [1:0] TX_SEND    = 2'd1;
   localparam logic [1:0] TX_WAIT_HI = 2'd2;
   localparam logic [1:0] TX_WAIT_LO = 2'd3;

   function automatic logic [7:0] status_byte(input logic drop, input logic rxerr,
                                              input logic done);
      return {5'b0, drop, rxerr, done};
   endfunction

endpackage

// File: rtl/uart_scope_if.sv
// Byte-level UART connection: receive strobes from the UART, transmit strobe/data to it.
// The responder is the master side; the UART (or its model) is the slave side.
interface uart_scope_if;

   logic       rx_received;
   logic [7:0] rx_byte;
   logic       rx_error;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;

   modport master (
      input  rx_received, rx_byte, rx_error, tx_busy,
      output tx_start, tx_data
   );

   modport slave (
      output rx_received, rx_byte, rx_error, tx_busy,
      input  tx_start, tx_data
   );

endinterface

// File: rtl/uart_byte_sender.sv
// Sends one byte through the UART: waits for idle, pulses tx_start, then waits for
// the UART to finish before pulsing done. tx_data holds until the next load.
module uart_byte_sender
   import uart_scope_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_byte,
   input  logic       tx_busy,
   output logic       done,
   output logic       tx_start,
   output logic [7:0] tx_data
);

   logic [1:0] state;

   // WAIT_HI skips one cycle so the UART has time to raise tx_busy after tx_start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= TX_IDLE;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         done     <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         done     <= 1'b0;
         case (state)
            TX_IDLE: begin
               if (load) begin
                  tx_data <= load_byte;
                  state   <= TX_SEND;
               end
            end
            TX_SEND: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  state    <= TX_WAIT_HI;
               end
            end
            TX_WAIT_HI: state <= TX_WAIT_LO;
            TX_WAIT_LO: begin
               if (!tx_busy) begin
                  done  <= 1'b1;
                  state <= TX_IDLE;
               end
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_scope_responder.sv
// Host command responder: decodes ARM/READ/STATUS bytes from the UART and answers
// with a framed capture-RAM dump or a status byte through uart_byte_sender.
module uart_scope_responder
   import uart_scope_pkg::*;
#(
   parameter int SAMPLE_AW = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_scope_if.master         uart,
   output logic [SAMPLE_AW-1:0] mem_addr,
   input  logic [7:0]           mem_rdata,
   input  logic                 capture_done,
   input  logic [SAMPLE_AW:0]   capture_len,
   output logic                 arm,
   output logic                 busy
);

   logic [3:0]         state;
   logic [15:0]        len;
   logic [SAMPLE_AW:0] remaining;
   logic [7:0]         csum;
   logic               drop_flag;
   logic               rxerr_flag;
   logic               sent;
   logic               byte_state;
   logic               load;
   logic [7:0]         load_byte;
   logic               done;
   logic               status_clear;

   always_comb begin
      byte_state = 1'b1;
      load_byte  = 8'h00;
      case (state)
         ST_HDR, ST_STAT_HDR: load_byte = SYNC_BYTE;
         ST_LEN_HI:           load_byte = len[15:8];
         ST_LEN_LO:           load_byte = len[7:0];
         ST_DATA:             load_byte = mem_rdata;
         ST_CSUM:             load_byte = csum;
         ST_STAT_BYTE:        load_byte = status_byte(drop_flag, rxerr_flag, capture_done);
         default:             byte_state = 1'b0;
      endcase
   end

   // Each byte-sending state issues exactly one load, then waits for the sender's done.
   assign load         = byte_state && !sent;
   assign busy         = (state != ST_IDLE);
   assign status_clear = (state == ST_STAT_BYTE) && load;

   uart_byte_sender u_sender (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_byte (load_byte),
      .tx_busy   (uart.tx_busy),
      .done      (done),
      .tx_start  (uart.tx_start),
      .tx_data   (uart.tx_data)
   );

   // A new event in the same cycle the status byte is loaded keeps its flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_flag  <= 1'b0;
         rxerr_flag <= 1'b0;
      end else begin
         drop_flag  <= (uart.rx_received && (state != ST_IDLE)) || (drop_flag && !status_clear);
         rxerr_flag <= uart.rx_error || (rxerr_flag && !status_clear);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         len       <= 16'h0000;
         remaining <= '0;
         csum      <= 8'h00;
         mem_addr  <= '0;
         arm       <= 1'b0;
         sent      <= 1'b0;
      end else begin
         arm <= 1'b0;
         if (load) begin
            sent <= 1'b1;
         end else if (done) begin
            sent <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (uart.rx_received) begin
                  case (uart.rx_byte)
                     CMD_ARM:    arm <= 1'b1;
                     CMD_READ: begin
                        len       <= capture_done ? 16'(capture_len) : 16'h0000;
                        remaining <= capture_done ? capture_len : '0;
                        mem_addr  <= '0;
                        csum      <= 8'h00;
                        state     <= ST_HDR;
                     end
                     CMD_STATUS: state <= ST_STAT_HDR;
                     default:    ;
                  endcase
               end
            end
            ST_HDR:    if (done) state <= ST_LEN_HI;
            ST_LEN_HI: if (done) state <= ST_LEN_LO;
            ST_LEN_LO: if (done) state <= (remaining == '0) ? ST_CSUM : ST_MEM_RD;
            ST_MEM_RD: state <= ST_DATA;
            ST_DATA: begin
               if (load) begin
                  csum <= csum + mem_rdata;
               end
               // The address stops on the last sample so it never wraps past the frame.
               if (done) begin
                  if (remaining == (SAMPLE_AW+1)'(1)) begin
                     state <= ST_CSUM;
                  end else begin
                     remaining <= remaining - (SAMPLE_AW+1)'(1);
                     mem_addr  <= mem_addr + SAMPLE_AW'(1);
                     state     <= ST_MEM_RD;
                  end
               end
            end
            ST_CSUM:      if (done) state <= ST_IDLE;
            ST_STAT_HDR:  if (done) state <= ST_STAT_BYTE;
            ST_STAT_BYTE: if (done) state <= ST_IDLE;
            default:      state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_scope_responder.sv
// Directed bench for uart_scope_responder with a byte-level UART model (20-cycle tx_busy),
// a RAM model holding RAM[i]=i+1, and a queue scoreboard of expected response bytes.
module tb_uart_scope_responder;
   import uart_scope_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] mem_addr;
   logic [7:0] mem_rdata = 8'h00;
   logic       capture_done;
   logic [10:0] capture_len;
   logic       arm;
   logic       busy;

   uart_scope_if bus ();

   uart_scope_responder #(.SAMPLE_AW(10)) dut (
      .clk          (clk),
      .rst          (rst),
      .uart         (bus),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .capture_done (capture_done),
      .capture_len  (capture_len),
      .arm          (arm),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         addr_q[$];
   int         busy_cnt = 0;
   int         starts = 0;
   int         cyc = 0;
   int         last_start = -1;
   int         min_gap = 1 << 30;
   int         arm_cnt = 0;
   int         busy_seen = 0;
   int         overlap_err = 0;

   initial bus.tx_busy = 1'b0;

   // UART transmit model: accepts a byte on tx_start and stays busy for 20 cycles.
   always @(negedge clk) begin
      cyc++;
      if (busy_cnt > 0) busy_cnt--;
      if (bus.tx_start === 1'b1) begin
         if (busy_cnt != 0) overlap_err++;
         got_q.push_back(bus.tx_data);
         addr_q.push_back(int'(mem_addr));
         starts++;
         if (last_start >= 0 && (cyc - last_start) < min_gap) min_gap = cyc - last_start;
         last_start = cyc;
         busy_cnt = 20;
      end
      bus.tx_busy = (busy_cnt != 0);
      if (arm === 1'b1) arm_cnt++;
      if (busy === 1'b1) busy_seen++;
   end

   always @(posedge clk) mem_rdata <= mem_addr[7:0] + 8'd1;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] b);
      @(negedge clk);
      bus.rx_byte     = b;
      bus.rx_received = 1'b1;
      @(negedge clk);
      bus.rx_received = 1'b0;
   endtask

   task automatic start_frame();
      exp_q.delete();
      got_q.delete();
      addr_q.delete();
      starts     = 0;
      last_start = -1;
      min_gap    = 1 << 30;
   endtask

   task automatic push_read(input int n);
      logic [7:0] sum;
      sum = 8'h00;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'((n >> 8) & 255));
      exp_q.push_back(8'(n & 255));
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(8'((i + 1) & 255));
         sum = sum + 8'((i + 1) & 255);
      end
      exp_q.push_back(sum);
   endtask

   task automatic wait_idle(input string tag, input int max_cycles);
      int k;
      k = 0;
      repeat (3) @(negedge clk);
      while (busy !== 1'b0 && k < max_cycles) begin
         @(negedge clk);
         k++;
      end
      check_output({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   task automatic check_frame(input string tag);
      check_output({tag, " count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size())
            check_output($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      end
   endtask

   initial begin
      rst             = 1'b1;
      bus.rx_received = 1'b0;
      bus.rx_byte     = 8'h00;
      bus.rx_error    = 1'b0;
      capture_done    = 1'b0;
      capture_len     = 11'd0;

      // Test 1: reset values, silence, then an empty READ
      repeat (3) @(negedge clk);
      check_output("rst tx_start", 32'(bus.tx_start), 32'd0);
      check_output("rst tx_data", 32'(bus.tx_data), 32'd0);
      check_output("rst mem_addr", 32'(mem_addr), 32'd0);
      check_output("rst arm", 32'(arm), 32'd0);
      check_output("rst busy", 32'(busy), 32'd0);
      rst = 1'b0;
      start_frame();
      repeat (100) @(negedge clk);
      check_output("quiet starts", starts, 0);
      push_read(0);
      apply_stimulus(CMD_READ);
      wait_idle("t1", 2000);
      check_frame("t1");

      // Test 2: four-sample READ, address sequence and byte spacing
      capture_done = 1'b1;
      capture_len  = 11'd4;
      start_frame();
      push_read(4);
      apply_stimulus(CMD_READ);
      wait_idle("t2", 2000);
      check_frame("t2");
      check_output("t2 starts", starts, 8);
      check_output("t2 gap ok", 32'(min_gap >= 21), 32'd1);
      for (int i = 0; i < 4; i++)
         if (addr_q.size() > 3 + i)
            check_output($sformatf("t2 addr%0d", i), addr_q[3 + i], i);

      // Test 3: full 1024-sample READ
      capture_len = 11'd1024;
      start_frame();
      push_read(1024);
      apply_stimulus(CMD_READ);
      wait_idle("t3", 40000);
      check_frame("t3");
      check_output("t3 final mem_addr", 32'(mem_addr), 32'd1023);
      if (addr_q.size() == 1028)
         check_output("t3 last addr", addr_q[1026], 1023);
      else
         check_output("t3 addr count", addr_q.size(), 1028);

      // Test 4: stray command and framing error during a READ
      capture_len = 11'd4;
      start_frame();
      push_read(4);
      apply_stimulus(CMD_READ);
      repeat (30) @(negedge clk);
      apply_stimulus(CMD_READ);
      bus.rx_error = 1'b1;
      @(negedge clk);
      bus.rx_error = 1'b0;
      wait_idle("t4", 2000);
      check_frame("t4");
      start_frame();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h07);
      apply_stimulus(CMD_STATUS);
      wait_idle("t4 stat1", 2000);
      check_frame("t4 stat1");
      start_frame();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h01);
      apply_stimulus(CMD_STATUS);
      wait_idle("t4 stat2", 2000);
      check_frame("t4 stat2");

      // Test 5: ARM and an unknown command
      start_frame();
      arm_cnt   = 0;
      busy_seen = 0;
      apply_stimulus(CMD_ARM);
      repeat (10) @(negedge clk);
      check_output("t5 arm pulses", arm_cnt, 1);
      check_output("t5 busy seen", busy_seen, 0);
      apply_stimulus(8'h55);
      repeat (40) @(negedge clk);
      check_output("t5 starts", starts, 0);
      check_output("t5 busy after 55", busy_seen, 0);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h01);
      apply_stimulus(CMD_STATUS);
      wait_idle("t5 stat", 2000);
      check_frame("t5 stat");

      // Test 6: reset after the third byte of a READ
      start_frame();
      push_read(4);
      apply_stimulus(CMD_READ);
      begin
         int k;
         k = 0;
         while (got_q.size() < 3 && k < 2000) begin
            @(negedge clk);
            k++;
         end
      end
      check_output("t6 bytes before rst", got_q.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < got_q.size())
            check_output($sformatf("t6 byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      rst = 1'b1;
      @(negedge clk);
      check_output("t6 tx_start", 32'(bus.tx_start), 32'd0);
      check_output("t6 tx_data", 32'(bus.tx_data), 32'd0);
      check_output("t6 mem_addr", 32'(mem_addr), 32'd0);
      check_output("t6 busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      start_frame();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h01);
      apply_stimulus(CMD_STATUS);
      wait_idle("t6 stat", 2000);
      check_frame("t6 stat");

      check_output("start while busy", overlap_err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
